// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package pc_sequencer_pkg;
  localparam int ADDR_W = 32;
  localparam int IMM_W  = 16;
  localparam int JT_W   = 26;

  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    EXEC  = 2'd1,
    ERROR = 2'd2
  } state_t;
endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: jump beats taken branch beats sequential PC+4.
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [ADDR_W-1:0]        pc,
  input  logic                     branch,
  input  logic                     condition,
  input  logic                     jump,
  input  logic signed [IMM_W-1:0]  imm16,
  input  logic [JT_W-1:0]          jtarget,
  output logic [ADDR_W-1:0]        next_pc
);

  logic [ADDR_W-1:0]        pc4;
  logic signed [ADDR_W-1:0] boff;

  // Word offset to byte offset; sign bit replicated before the shift.
  function automatic logic signed [ADDR_W-1:0] word_offset(input logic signed [IMM_W-1:0] imm);
    logic signed [ADDR_W-1:0] ext;
    ext = {{(ADDR_W-IMM_W){imm[IMM_W-1]}}, imm};
    return ext <<< 2;
  endfunction

  always_comb begin
    pc4     = pc + PC_STEP;
    boff    = word_offset(imm16);
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[ADDR_W-1:ADDR_W-4], jtarget, 2'b00};
    end else if (branch && condition) begin
      next_pc = pc4 + $unsigned(boff);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter owner: fetches one instruction, holds it until retirement,
// then loads the next PC. A fetch that outlasts TIMEOUT cycles locks in ERROR.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        stall,
  input  logic        branch,
  input  logic        condition,
  input  logic        jump,
  input  logic [15:0] imm16,
  input  logic [25:0] jtarget,
  output logic [31:0] pc,
  output logic        fetch_err
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [7:0]        wait_cnt;
  logic [ADDR_W-1:0] next_pc;
  logic              fetch_done;
  logic              retire;
  logic              timeout_hit;

  next_pc_calc u_next_pc (
    .pc        (pc),
    .branch    (branch),
    .condition (condition),
    .jump      (jump),
    .imm16     (imm16),
    .jtarget   (jtarget),
    .next_pc   (next_pc)
  );

  always_comb begin
    state_nx    = state;
    fetch_done  = 1'b0;
    retire      = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      REQ: begin
        if (imem_ready) begin
          fetch_done = 1'b1;
          state_nx   = EXEC;
        end else if (wait_cnt == CNT_LAST) begin
          timeout_hit = 1'b1;
          state_nx    = ERROR;
        end
      end
      EXEC: begin
        if (!stall) begin
          retire   = 1'b1;
          state_nx = REQ;
        end
      end
      ERROR:   state_nx = ERROR;
      default: state_nx = REQ;
    endcase
  end

  // Request is suppressed while reset is held so memory never sees a stale fetch.
  assign imem_req  = (state == REQ) && !reset;
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      state <= state_nx;
      if (state == REQ) begin
        wait_cnt <= fetch_done ? 8'd0 : wait_cnt + 8'd1;
      end
      if (fetch_done) begin
        instr       <= imem_rdata;
        instr_valid <= 1'b1;
      end
      if (retire) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
      if (timeout_hit) begin
        fetch_err <= 1'b1;
      end
    end
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle instruction-fetch sequencer that owns the program counter. It requests each instruction from instruction memory with a req/ready handshake and holds the fetched word for the decode/execute stage. It then selects and loads the next PC from PC+4, the branch target or the jump target. It replaces the free-running PC register plus adder chain with one controlled block, and flags instruction-memory timeouts.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 16, maximum cycles to wait for imem_ready before a fetch error (range 1..255).

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; equals pc.
imem_ready  input  1  memory has valid imem_rdata this cycle.
imem_rdata  input  32  fetched instruction word.
instr  output  32  latched instruction for decode.
instr_valid  output  1  instr is valid and awaiting retirement.
stall  input  1  execute stage not done; hold current instruction.
branch  input  1  instruction is a conditional branch.
condition  input  1  branch condition (ALU zero / compare result).
jump  input  1  instruction is a jump.
imm16  input  16  branch offset in words, signed.
jtarget  input  26  jump target field.
pc  output  32  current PC.
fetch_err  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, fetch_err=0, wait counter=0, state=REQ. Reset wins over every other input in the same cycle, including a mid-wait fetch.
- States: REQ, EXEC, ERROR.
- REQ:
  - imem_req=1, imem_addr=pc, counter increments each cycle.
  - If imem_ready: instr<=imem_rdata, instr_valid<=1, counter<=0, go to EXEC. A ready on the first REQ cycle is a 1-cycle fetch.
  - Else if counter==TIMEOUT-1: fetch_err<=1, go to ERROR.
- EXEC:
  - imem_req=0, instr_valid=1.
  - If stall: hold everything.
  - Else retire: pc<=next_pc, instr_valid<=0, go to REQ.
  - Retire-to-next-request latency is 1 cycle.
- ERROR: imem_req=0, instr_valid=0, pc frozen. Exits only on reset.
- imem_ready outside REQ is ignored.
- next_pc (all arithmetic modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal):
  - pc4 = pc+4.
  - Jump has priority: next_pc = {pc4[31:28], jtarget, 2'b00}.
  - Else if branch & condition: next_pc = pc4 + ({{16{imm16[15]}}, imm16} << 2). Sign extension is always signed.
  - Else next_pc = pc4.
- branch, condition, jump, imm16 and jtarget are sampled only in the EXEC retire cycle.
- Invariant: pc[1:0] stays 2'b00; no misalignment case exists.

Decomposition:
- Shared package holds:
  - State encoding: REQ=2'd0, EXEC=2'd1, ERROR=2'd2.
  - Constant PC_STEP=4.
  - Width constants ADDR_W=32, IMM_W=16, JT_W=26.
- One combinational sub-module, next_pc_calc: inputs pc, branch, condition, jump, imm16, jtarget; output next_pc. It is unit-testable on its own.
- FSM, wait counter and PC/instr registers stay in pc_sequencer.

Test Plan:
1. Reset, then imem_ready=1 on every REQ cycle, rdata=32'h2001_0005, no branch/jump, stall=0 -> pc runs 0,4,8,C. REQ and EXEC alternate each cycle; instr=32'h2001_0005.
2. pc=32'h40, ready delayed 3 cycles -> imem_req high 4 cycles with imem_addr=32'h40; instr_valid rises the cycle after ready; counter clears.
3. pc=32'h100, branch=1, condition=1, imm16=16'hFFFE -> next pc=32'hFC. Same with condition=0 -> 32'h104.
4. pc=32'h1000_0010, jump=1, branch=1, condition=1, jtarget=26'h0000_040 -> pc=32'h1000_0100 (jump beats branch).
5. stall=1 held 5 cycles in EXEC -> pc, instr and instr_valid unchanged, imem_req=0. Retire happens on the first stall=0 cycle.
6. TIMEOUT=16, ready never asserted -> fetch_err=1 after 16 REQ cycles; state stays ERROR for 20 more cycles.
7. Reset asserted during a REQ wait -> pc=RESET_PC and fetch_err=0 next cycle, then fetch restarts.
